// File: rtl/hyperbus_burst_fifo.sv
// hyperbus_burst_fifo: in-order burst command/data queue in front of a
// Hyperbus native controller; user words travel as MSB-first beats.
// Ports: cmd_* command push, tx_* write-word push, rx_* read-word pop
// (first-word-fall-through), busy status, hbus_* controller side with
// hbus_wrq/hbus_rrq held high for the whole burst.
module hyperbus_burst_fifo #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int CMD_AW          = 2,
  parameter int DAT_AW          = 4,
  parameter int MAX_BURST       = 8,
  parameter int LEN_W           = $clog2(MAX_BURST + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_we,
  input  logic [HBUS_ADDR_WIDTH-1:0] cmd_adr,
  input  logic [LEN_W-1:0]           cmd_len,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic [FIFO_DATA_WIDTH-1:0] tx_dat,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [FIFO_DATA_WIDTH-1:0] rx_dat,
  output logic                       busy,
  output logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_o,
  output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
  input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
  output logic                       hbus_wrq,
  output logic                       hbus_rrq,
  input  logic                       hbus_ready,
  input  logic                       hbus_valid,
  input  logic                       hbus_busy
);

  localparam int FW    = FIFO_DATA_WIDTH;
  localparam int HW    = HBUS_DATA_WIDTH;
  localparam int RATIO = FW / HW;
  localparam int SUB_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int BW    = LEN_W + $clog2(RATIO) + 1;
  localparam int CDEP  = 2 ** CMD_AW;
  localparam int DDEP  = 2 ** DAT_AW;
  localparam int CW    = 1 + HBUS_ADDR_WIDTH + LEN_W;
  localparam int PW    = DAT_AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;

  logic [CW-1:0]      cmd_mem [CDEP];
  logic [CMD_AW:0]    cmd_wp;
  logic [CMD_AW:0]    cmd_rp;
  logic [FW-1:0]      tx_mem [DDEP];
  logic [PW-1:0]      tx_wp;
  logic [PW-1:0]      tx_rp;
  logic [PW-1:0]      tx_rp_nxt;
  logic [PW-1:0]      tx_cnt;
  logic [FW-1:0]      rx_mem [DDEP];
  logic [PW-1:0]      rx_wp;
  logic [PW-1:0]      rx_rp;
  logic [PW-1:0]      rx_cnt;
  logic [PW-1:0]      rx_free;

  logic [1:0]         state;
  logic [FW-1:0]      tx_shift;
  logic [FW-1:0]      rx_shift;
  logic [FW-1:0]      rx_word;
  logic [SUB_W-1:0]   sub;
  logic [BW-1:0]      beat_cnt;

  logic [LEN_W-1:0]   len_clamp;
  logic               head_we;
  logic [HBUS_ADDR_WIDTH-1:0] head_adr;
  logic [LEN_W-1:0]   head_len;
  logic [PW-1:0]      need;

  logic cmd_empty;
  logic cmd_full;
  logic tx_full;
  logic cmd_push;
  logic tx_push;
  logic tx_pop;
  logic rx_push;
  logic rx_pop;
  logic go_wr;
  logic go_rd;
  logic wr_beat;
  logic rd_beat;
  logic word_end;
  logic last_beat;

  always_comb begin
    len_clamp = cmd_len;
    if (cmd_len == '0)
      len_clamp = LEN_W'(1);
    else if (cmd_len > LEN_W'(MAX_BURST))
      len_clamp = LEN_W'(MAX_BURST);
  end

  assign {head_we, head_adr, head_len} =
    cmd_mem[cmd_rp[CMD_AW-1:0]];

  assign cmd_empty = (cmd_wp == cmd_rp);
  assign cmd_full  = ((cmd_wp ^ cmd_rp) ==
                      {1'b1, {CMD_AW{1'b0}}});
  assign cmd_ready = !cmd_full;
  assign cmd_push  = cmd_valid && cmd_ready;

  assign tx_cnt    = tx_wp - tx_rp;
  assign tx_rp_nxt = tx_rp + PW'(1);
  assign tx_full   = (tx_cnt == PW'(DDEP));
  assign tx_ready  = !tx_full;
  assign tx_push   = tx_valid && tx_ready;

  assign rx_cnt    = rx_wp - rx_rp;
  assign rx_free   = PW'(DDEP) - rx_cnt;
  assign rx_valid  = (rx_cnt != '0);
  assign rx_dat    = rx_mem[rx_rp[DAT_AW-1:0]];
  assign rx_pop    = rx_valid && rx_ready;

  // Reads launch only from IDLE, when every word of the previous
  // burst is already in the RX FIFO, so rx_free covers in-flight data.
  assign need  = PW'(head_len);
  assign go_wr = (state == S_IDLE) && !cmd_empty && head_we &&
                 !hbus_busy && (tx_cnt >= need);
  assign go_rd = (state == S_IDLE) && !cmd_empty && !head_we &&
                 !hbus_busy && (rx_free >= need);

  assign wr_beat   = (state == S_WRITE) && hbus_ready;
  assign rd_beat   = (state == S_READ) && hbus_valid;
  assign word_end  = (sub == SUB_W'(RATIO - 1));
  assign last_beat = (beat_cnt == BW'(1));
  assign tx_pop    = wr_beat && word_end;
  assign rx_push   = rd_beat && word_end;
  assign rx_word   = (rx_shift << HW) | FW'(hbus_dat_i);

  assign hbus_wrq   = (state == S_WRITE);
  assign hbus_rrq   = (state == S_READ);
  assign hbus_dat_o = tx_shift[FW-1 -: HW];
  assign busy       = (state != S_IDLE) || !cmd_empty ||
                      (tx_cnt != '0) || rx_valid;

  always_ff @(posedge clk) begin
    if (cmd_push)
      cmd_mem[cmd_wp[CMD_AW-1:0]] <= {cmd_we, cmd_adr, len_clamp};
    if (tx_push)
      tx_mem[tx_wp[DAT_AW-1:0]] <= tx_dat;
    if (rx_push)
      rx_mem[rx_wp[DAT_AW-1:0]] <= rx_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wp     <= '0;
      cmd_rp     <= '0;
      tx_wp      <= '0;
      tx_rp      <= '0;
      rx_wp      <= '0;
      rx_rp      <= '0;
      state      <= S_IDLE;
      hbus_adr_o <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      sub        <= '0;
      beat_cnt   <= '0;
    end else begin
      if (cmd_push)
        cmd_wp <= cmd_wp + (CMD_AW+1)'(1);
      if (go_wr || go_rd)
        cmd_rp <= cmd_rp + (CMD_AW+1)'(1);
      if (tx_push)
        tx_wp <= tx_wp + PW'(1);
      if (tx_pop)
        tx_rp <= tx_rp_nxt;
      if (rx_push)
        rx_wp <= rx_wp + PW'(1);
      if (rx_pop)
        rx_rp <= rx_rp + PW'(1);
      unique case (1'b1)
        go_wr: begin
          state      <= S_WRITE;
          hbus_adr_o <= head_adr;
          tx_shift   <= tx_mem[tx_rp[DAT_AW-1:0]];
          sub        <= '0;
          beat_cnt   <= BW'(head_len) * BW'(RATIO);
        end
        go_rd: begin
          state      <= S_READ;
          hbus_adr_o <= head_adr;
          rx_shift   <= '0;
          sub        <= '0;
          beat_cnt   <= BW'(head_len) * BW'(RATIO);
        end
        wr_beat: begin
          // The last beat shifts out to zero rather than
          // prefetching a word that belongs to a later burst.
          if (word_end && !last_beat)
            tx_shift <= tx_mem[tx_rp_nxt[DAT_AW-1:0]];
          else
            tx_shift <= tx_shift << HW;
          sub      <= word_end ? '0 : sub + SUB_W'(1);
          beat_cnt <= beat_cnt - BW'(1);
          if (last_beat)
            state <= S_IDLE;
        end
        rd_beat: begin
          rx_shift <= rx_word;
          sub      <= word_end ? '0 : sub + SUB_W'(1);
          beat_cnt <= beat_cnt - BW'(1);
          if (last_beat)
            state <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_burst_fifo.sv
// tb_hyperbus_burst_fifo: directed steps plus a randomized phase, checked
// against queue models of the command, beat and word streams.
module tb_hyperbus_burst_fifo;

  localparam int FW    = 32;
  localparam int HW    = 16;
  localparam int AW    = 32;
  localparam int LW    = 4;
  localparam int RATIO = FW / HW;
  localparam int MAXB  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [FW-1:0] tx_dat = '0;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [FW-1:0] rx_dat;
  logic          busy;
  logic [AW-1:0] hbus_adr_o;
  logic [HW-1:0] hbus_dat_o;
  logic [HW-1:0] hbus_dat_i = '0;
  logic          hbus_wrq;
  logic          hbus_rrq;
  logic          hbus_ready = 1'b0;
  logic          hbus_valid = 1'b0;
  logic          hbus_busy = 1'b0;

  hyperbus_burst_fifo #(
    .FIFO_DATA_WIDTH(FW),
    .HBUS_DATA_WIDTH(HW),
    .HBUS_ADDR_WIDTH(AW),
    .CMD_AW(2),
    .DAT_AW(4),
    .MAX_BURST(MAXB),
    .LEN_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dat(tx_dat),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_dat(rx_dat),
    .busy(busy), .hbus_adr_o(hbus_adr_o),
    .hbus_dat_o(hbus_dat_o), .hbus_dat_i(hbus_dat_i),
    .hbus_wrq(hbus_wrq), .hbus_rrq(hbus_rrq),
    .hbus_ready(hbus_ready), .hbus_valid(hbus_valid),
    .hbus_busy(hbus_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [AW-1:0] adr;
    int          len;
  } cmd_t;

  cmd_t          cmd_pend[$];
  cmd_t          ecmd[$];
  logic [FW-1:0] tx_pend[$];
  logic [HW-1:0] wbeats[$];
  logic [FW-1:0] erx[$];

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_pct = 100;
  int vld_pct = 100;
  int pop_pct = 100;
  int pop_budget = 0;
  bit noise = 0;
  bit seq_mode = 0;
  bit busy_rand = 0;
  bit busy_force = 0;
  logic [HW-1:0] seq_val = '0;
  bit prev_wrq = 0;
  bit prev_rrq = 0;
  bit cur_full = 0;
  int cur_len = 0;
  int cur_beats = 0;
  int cur_cycles = 0;
  int n_starts = 0;
  int hi_cnt = 0;
  logic [FW-1:0] acc = '0;
  int acc_n = 0;

  function automatic int clamp(input int l);
    if (l == 0) return 1;
    if (l > MAXB) return MAXB;
    return l;
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic add_cmd(input bit we, input logic [AW-1:0] adr,
                         input int len);
    cmd_t c;
    c.we = we;
    c.adr = adr;
    c.len = len;
    cmd_pend.push_back(c);
  endtask

  // One cycle: observe at the falling edge, update the model, then
  // drive inputs for the next rising edge.
  task automatic step();
    cmd_t c;
    logic [FW-1:0] w;
    @(negedge clk);
    check("rx_valid", rx_valid, 64'(erx.size() != 0));
    if (hbus_wrq || hbus_rrq) hi_cnt++;
    if ((!hbus_wrq && prev_wrq) || (!hbus_rrq && prev_rrq)) begin
      check("burst_beats", cur_beats, cur_len);
      if (cur_full) check("burst_cycles", cur_cycles, cur_len);
    end
    if ((hbus_wrq && !prev_wrq) || (hbus_rrq && !prev_rrq)) begin
      n_starts++;
      check("gap", prev_wrq | prev_rrq, 1'b0);
      check("both_rq", hbus_wrq & hbus_rrq, 1'b0);
      check("start_expected", 64'(ecmd.size() != 0), 64'd1);
      if (ecmd.size() != 0) begin
        c = ecmd.pop_front();
        check("kind", hbus_wrq, c.we);
        check("adr", hbus_adr_o, c.adr);
        cur_len = c.len * RATIO;
      end
      cur_beats = 0;
      cur_cycles = 0;
      cur_full = hbus_wrq ? (rdy_pct == 100) : (vld_pct == 100);
    end
    prev_wrq = hbus_wrq;
    prev_rrq = hbus_rrq;
    if (hbus_wrq || hbus_rrq) cur_cycles++;

    hbus_ready = hbus_wrq ? ($urandom_range(99) < rdy_pct)
                          : (noise && $urandom_range(1) == 1);
    hbus_valid = hbus_rrq ? ($urandom_range(99) < vld_pct)
                          : (noise && $urandom_range(1) == 1);
    hbus_dat_i = HW'($urandom);
    hbus_busy = busy_rand ? ($urandom_range(3) == 0) : busy_force;
    if (hbus_wrq && hbus_ready) begin
      cur_beats++;
      check("wbeat_avail", 64'(wbeats.size() != 0), 64'd1);
      if (wbeats.size() != 0)
        check("wbeat", hbus_dat_o, wbeats.pop_front());
    end
    if (hbus_rrq && hbus_valid) begin
      if (seq_mode) begin
        hbus_dat_i = seq_val;
        seq_val++;
      end
      cur_beats++;
      acc = (acc << HW) | FW'(hbus_dat_i);
      acc_n++;
      if (acc_n == RATIO) begin
        erx.push_back(acc);
        acc = '0;
        acc_n = 0;
      end
    end

    rx_ready = 1'b0;
    if (rx_valid && pop_budget > 0 &&
        $urandom_range(99) < pop_pct) begin
      rx_ready = 1'b1;
      pop_budget--;
      check("rx_avail", 64'(erx.size() != 0), 64'd1);
      if (erx.size() != 0)
        check("rx_dat", rx_dat, erx.pop_front());
    end

    cmd_valid = 1'b0;
    if (cmd_ready && cmd_pend.size() != 0) begin
      c = cmd_pend.pop_front();
      cmd_valid = 1'b1;
      cmd_we = c.we;
      cmd_adr = c.adr;
      cmd_len = LW'(c.len);
      c.len = clamp(c.len);
      ecmd.push_back(c);
    end

    tx_valid = 1'b0;
    if (tx_ready && tx_pend.size() != 0) begin
      w = tx_pend.pop_front();
      tx_valid = 1'b1;
      tx_dat = w;
      for (int k = 0; k < RATIO; k++)
        wbeats.push_back(w[FW-1-k*HW -: HW]);
    end
  endtask

  task automatic wait_quiet(input int bound);
    int k = 0;
    while (k < bound && (cmd_pend.size() != 0 ||
           ecmd.size() != 0 || hbus_wrq || hbus_rrq)) begin
      step();
      k++;
    end
    check("quiet_timeout", 64'(k < bound), 64'd1);
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    pop_budget = 1000000;
    while (k < bound && (cmd_pend.size() != 0 ||
           ecmd.size() != 0 || tx_pend.size() != 0 ||
           wbeats.size() != 0 || erx.size() != 0 ||
           hbus_wrq || hbus_rrq || busy)) begin
      step();
      k++;
    end
    check("idle_timeout", 64'(k < bound), 64'd1);
  endtask

  initial begin
    int k;
    int s0;
    cmd_t c;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_wrq", hbus_wrq, 1'b0);
    check("rst_rrq", hbus_rrq, 1'b0);
    check("rst_adr", hbus_adr_o, '0);
    check("rst_dat", hbus_dat_o, '0);
    check("rst_rxv", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", cmd_ready, 1'b1);
    check("rel_tx_ready", tx_ready, 1'b1);

    // single-word write: launch latency and two-beat burst
    tx_pend.push_back(32'hDEADBEEF);
    repeat (3) step();
    add_cmd(1'b1, 32'h100, 1);
    step();
    step();
    check("lat_wait", hbus_wrq, 1'b0);
    step();
    check("lat_wrq", hbus_wrq, 1'b1);
    check("w1_adr", hbus_adr_o, 32'h100);
    check("w1_beat0", hbus_dat_o, 16'hDEAD);
    step();
    check("w1_beat1", hbus_dat_o, 16'hBEEF);
    wait_idle(100);

    // read len 4 with counting beats
    seq_mode = 1'b1;
    seq_val = 16'h0001;
    pop_budget = 0;
    add_cmd(1'b0, 32'h40, 4);
    wait_quiet(100);
    check("r4_head", rx_dat, 32'h00010002);
    wait_idle(100);
    seq_mode = 1'b0;

    // write len 4 waits for its fourth word
    add_cmd(1'b1, 32'h800, 4);
    repeat (3) tx_pend.push_back($urandom);
    hi_cnt = 0;
    repeat (15) step();
    check("w_wait_data", hi_cnt, 0);
    tx_pend.push_back($urandom);
    wait_idle(100);

    // read blocked by RX space
    pop_budget = 0;
    add_cmd(1'b0, 32'h1000, 8);
    add_cmd(1'b0, 32'h1100, 2);
    wait_quiet(200);
    add_cmd(1'b0, 32'h1200, 8);
    hi_cnt = 0;
    repeat (20) step();
    check("r_wait_space", hi_cnt, 0);
    check("r_wait_busy", busy, 1'b1);
    pop_budget = 2;
    s0 = n_starts;
    k = 0;
    while (n_starts == s0 && k < 20) begin
      step();
      k++;
    end
    check("r_launch", n_starts - s0, 1);
    wait_idle(200);

    // full command FIFO, controller busy, lengths 0 and 15
    busy_force = 1'b1;
    repeat (10) tx_pend.push_back($urandom);
    add_cmd(1'b1, 32'h200, 1);
    add_cmd(1'b0, 32'h300, 2);
    add_cmd(1'b1, 32'h400, 0);
    add_cmd(1'b0, 32'h500, 15);
    add_cmd(1'b1, 32'h600, 12);
    hi_cnt = 0;
    repeat (16) step();
    check("cmd_full", cmd_ready, 1'b0);
    check("cmd_left", cmd_pend.size(), 1);
    check("busy_hold", hi_cnt, 0);
    busy_force = 1'b0;
    wait_idle(500);

    // full TX FIFO
    repeat (17) tx_pend.push_back($urandom);
    repeat (20) step();
    check("tx_full", tx_ready, 1'b0);
    add_cmd(1'b1, 32'h900, 8);
    add_cmd(1'b1, 32'hA00, 8);
    add_cmd(1'b1, 32'hB00, 1);
    wait_idle(300);

    // reset during beat 3 of an 8-word write
    repeat (8) tx_pend.push_back($urandom);
    add_cmd(1'b1, 32'h700, 8);
    k = 0;
    while (!(hbus_wrq && cur_beats == 2) && k < 100) begin
      step();
      k++;
    end
    check("rst_reach", cur_beats, 2);
    @(posedge clk);
    #1;
    check("pre_rst_wrq", hbus_wrq, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_wrq", hbus_wrq, 1'b0);
    check("async_dat", hbus_dat_o, '0);
    cmd_valid = 1'b0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    hbus_ready = 1'b0;
    hbus_valid = 1'b0;
    cmd_pend.delete();
    ecmd.delete();
    tx_pend.delete();
    wbeats.delete();
    erx.delete();
    acc = '0;
    acc_n = 0;
    prev_wrq = 0;
    prev_rrq = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_busy", busy, 1'b0);
    check("post_rxv", rx_valid, 1'b0);
    check("post_cmd_ready", cmd_ready, 1'b1);
    check("post_tx_ready", tx_ready, 1'b1);
    check("post_adr", hbus_adr_o, '0);

    // randomized traffic
    noise = 1'b1;
    busy_rand = 1'b1;
    rdy_pct = 60;
    vld_pct = 70;
    pop_pct = 50;
    pop_budget = 1000000;
    for (int i = 0; i < 40; i++) begin
      c.we = 1'($urandom_range(1));
      c.adr = $urandom;
      c.len = $urandom_range(15);
      if (c.we)
        for (int j = 0; j < clamp(c.len); j++)
          tx_pend.push_back($urandom);
      cmd_pend.push_back(c);
      repeat ($urandom_range(6)) step();
    end
    wait_idle(6000);
    check("end_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
